// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: picks a triggered effect by fixed priority and steps
// through its hardwired {frequency, duration} note table for the tone divider.
module sfx_sequencer #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_req,
  output logic [23:0] o_freq,
  output logic        o_tone_en,
  output logic        o_busy,
  output logic [1:0]  o_active_id
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [1:0]    step_q, step_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    dur_cnt_q, dur_cnt_d;
  logic [3:0]    req_q, req_d;
  logic          armed_q, armed_d;
  logic [23:0]   freq_q, freq_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;
  logic [1:0]    active_id_q, active_id_d;

  logic [3:0]    req_edge;
  logic          req_valid;
  logic [1:0]    win_id;
  logic          tick;
  logic          preempt;
  logic [10:0]   tbl_freq;
  logic [7:0]    tbl_dur;
  logic          tbl_last;

  // The first sampled edge after reset only primes req_q, so a level held
  // through reset is never mistaken for a fresh request.
  assign req_edge  = i_req & ~req_q;
  assign req_valid = armed_q & (|req_edge);
  assign tick      = (tick_cnt_q == TICK_LAST);
  assign preempt   = req_valid && (win_id >= id_q);

  always_comb begin
    win_id = 2'd0;
    if (req_edge[3])      win_id = 2'd3;
    else if (req_edge[2]) win_id = 2'd2;
    else if (req_edge[1]) win_id = 2'd1;
  end

  always_comb begin
    tbl_freq = 11'd0;
    tbl_dur  = 8'd1;
    tbl_last = 1'b1;
    case ({id_q, step_q})
      4'b0000: begin tbl_freq = 11'd880;  tbl_dur = 8'd30;  tbl_last = 1'b0; end
      4'b0001: begin tbl_freq = 11'd660;  tbl_dur = 8'd30;  tbl_last = 1'b0; end
      4'b0010: begin tbl_freq = 11'd440;  tbl_dur = 8'd30;  tbl_last = 1'b1; end
      4'b0100: begin tbl_freq = 11'd220;  tbl_dur = 8'd50;  tbl_last = 1'b0; end
      4'b0101: begin tbl_freq = 11'd0;    tbl_dur = 8'd20;  tbl_last = 1'b0; end
      4'b0110: begin tbl_freq = 11'd220;  tbl_dur = 8'd50;  tbl_last = 1'b1; end
      4'b1000: begin tbl_freq = 11'd110;  tbl_dur = 8'd100; tbl_last = 1'b0; end
      4'b1001: begin tbl_freq = 11'd80;   tbl_dur = 8'd100; tbl_last = 1'b0; end
      4'b1010: begin tbl_freq = 11'd60;   tbl_dur = 8'd150; tbl_last = 1'b1; end
      4'b1100: begin tbl_freq = 11'd523;  tbl_dur = 8'd80;  tbl_last = 1'b0; end
      4'b1101: begin tbl_freq = 11'd659;  tbl_dur = 8'd80;  tbl_last = 1'b0; end
      4'b1110: begin tbl_freq = 11'd784;  tbl_dur = 8'd80;  tbl_last = 1'b0; end
      4'b1111: begin tbl_freq = 11'd1047; tbl_dur = 8'd160; tbl_last = 1'b1; end
      default: begin tbl_freq = 11'd0;    tbl_dur = 8'd1;   tbl_last = 1'b1; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    step_d      = step_q;
    tick_cnt_d  = tick_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    req_d       = i_req;
    armed_d     = 1'b1;
    freq_d      = freq_q;
    tone_en_d   = tone_en_q;
    busy_d      = busy_q;
    active_id_d = active_id_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = LOAD;
          id_d    = win_id;
          step_d  = 2'd0;
        end
      end
      // A qualifying edge here retargets the load; the old note keeps sounding one more cycle.
      LOAD: begin
        if (preempt) begin
          id_d   = win_id;
          step_d = 2'd0;
        end else begin
          freq_d      = {13'd0, tbl_freq};
          tone_en_d   = (tbl_freq != 11'd0);
          busy_d      = 1'b1;
          active_id_d = id_q;
          tick_cnt_d  = '0;
          dur_cnt_d   = 8'd0;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (preempt) begin
          state_d = LOAD;
          id_d    = win_id;
          step_d  = 2'd0;
        end else if (tick) begin
          tick_cnt_d = '0;
          if (dur_cnt_q == tbl_dur - 8'd1) begin
            if (tbl_last) begin
              state_d     = IDLE;
              freq_d      = 24'd0;
              tone_en_d   = 1'b0;
              busy_d      = 1'b0;
              active_id_d = 2'd0;
            end else begin
              step_d  = step_q + 2'd1;
              state_d = LOAD;
            end
          end else begin
            dur_cnt_d = dur_cnt_q + 8'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      id_q        <= 2'd0;
      step_q      <= 2'd0;
      tick_cnt_q  <= '0;
      dur_cnt_q   <= 8'd0;
      req_q       <= 4'd0;
      armed_q     <= 1'b0;
      freq_q      <= 24'd0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      step_q      <= step_d;
      tick_cnt_q  <= tick_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
      req_q       <= req_d;
      armed_q     <= armed_d;
      freq_q      <= freq_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
    end
  end

  assign o_freq      = freq_q;
  assign o_tone_en   = tone_en_q;
  assign o_busy      = busy_q;
  assign o_active_id = active_id_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV=10; outputs are packed as
// {freq, tone_en, busy, active_id} and compared against hand-computed values.
module tb_sfx_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [23:0] o_freq;
  logic        o_tone_en;
  logic        o_busy;
  logic [1:0]  o_active_id;

  logic [27:0] obs;
  logic [27:0] exp_v;
  int vectors = 0;
  int miscompares = 0;

  assign obs = {o_freq, o_tone_en, o_busy, o_active_id};

  sfx_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .o_freq      (o_freq),
    .o_tone_en   (o_tone_en),
    .o_busy      (o_busy),
    .o_active_id (o_active_id)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns 1 time unit after the n-th following rising edge.
  task automatic step_n(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Request is sampled high at the next edge k; returns just after edge k.
  task automatic pulse(input logic [3:0] bits);
    i_req = bits;
    step_n(1);
    i_req = 4'b0000;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_req   = 4'b1000;
    #12;
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL reset_state: got %h want %h", obs, exp_v); end
    step_n(1);
    i_rst_n = 1'b1;
    step_n(5);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL held_through_reset: got %h want %h", obs, exp_v); end
    i_req = 4'b0000;
    step_n(2);
  endtask

  task automatic test_reset_mid_note;
    pulse(4'b0100);
    step_n(1);
    exp_v = {24'd110, 1'b1, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL expl_start: got %h want %h", obs, exp_v); end
    step_n(400);
    #3;
    i_rst_n = 1'b0;
    #1;
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL async_reset: got %h want %h", obs, exp_v); end
    step_n(1);
    i_rst_n = 1'b1;
    i_req   = 4'b0000;
    step_n(50);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL idle_after_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_shoot;
    pulse(4'b0001);
    step_n(1);
    exp_v = {24'd880, 1'b1, 1'b1, 2'd0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_880: got %h want %h", obs, exp_v); end
    step_n(300);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_880_gap: got %h want %h", obs, exp_v); end
    step_n(1);
    exp_v = {24'd660, 1'b1, 1'b1, 2'd0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_660: got %h want %h", obs, exp_v); end
    step_n(301);
    exp_v = {24'd440, 1'b1, 1'b1, 2'd0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_440: got %h want %h", obs, exp_v); end
    step_n(299);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_last_cycle: got %h want %h", obs, exp_v); end
    step_n(1);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL shoot_end: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_rest_step;
    pulse(4'b0010);
    step_n(1);
    exp_v = {24'd220, 1'b1, 1'b1, 2'd1};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL hit_220: got %h want %h", obs, exp_v); end
    step_n(501);
    exp_v = {24'd0, 1'b0, 1'b1, 2'd1};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL hit_rest: got %h want %h", obs, exp_v); end
    step_n(200);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL hit_rest_end: got %h want %h", obs, exp_v); end
    step_n(1);
    exp_v = {24'd220, 1'b1, 1'b1, 2'd1};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL hit_220_again: got %h want %h", obs, exp_v); end
    step_n(500);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL hit_end: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_preempt;
    pulse(4'b0001);
    step_n(302);
    exp_v = {24'd660, 1'b1, 1'b1, 2'd0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL pre_660: got %h want %h", obs, exp_v); end
    step_n(50);
    pulse(4'b0100);
    step_n(1);
    exp_v = {24'd110, 1'b1, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL preempt_110: got %h want %h", obs, exp_v); end
    step_n(100);
    pulse(4'b0010);
    step_n(2);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL low_ignored: got %h want %h", obs, exp_v); end
    step_n(898);
    exp_v = {24'd80, 1'b1, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL expl_80: got %h want %h", obs, exp_v); end
    step_n(1001);
    exp_v = {24'd60, 1'b1, 1'b1, 2'd2};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL expl_60: got %h want %h", obs, exp_v); end
    step_n(1499);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL expl_60_last: got %h want %h", obs, exp_v); end
    step_n(1);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL expl_end: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_simultaneous;
    pulse(4'b1011);
    step_n(1);
    exp_v = {24'd523, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL simul_523: got %h want %h", obs, exp_v); end
    step_n(4003);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL lvlup_end: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_held;
    i_req = 4'b1000;
    step_n(2);
    exp_v = {24'd523, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL held_523: got %h want %h", obs, exp_v); end
    step_n(4003);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL held_one_shot: got %h want %h", obs, exp_v); end
    step_n(996);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL held_no_retrigger: got %h want %h", obs, exp_v); end
    i_req = 4'b0000;
    step_n(1);
    pulse(4'b1000);
    step_n(1);
    exp_v = {24'd523, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL retrigger_after_low: got %h want %h", obs, exp_v); end
    step_n(4003);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL retrigger_end: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_same_id_restart;
    pulse(4'b1000);
    step_n(1603);
    exp_v = {24'd784, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL lvlup_784: got %h want %h", obs, exp_v); end
    step_n(100);
    pulse(4'b1000);
    step_n(1);
    exp_v = {24'd523, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL restart_523: got %h want %h", obs, exp_v); end
    step_n(800);
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL restart_523_gap: got %h want %h", obs, exp_v); end
    step_n(1);
    exp_v = {24'd659, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL restart_659: got %h want %h", obs, exp_v); end
    step_n(1602);
    exp_v = {24'd1047, 1'b1, 1'b1, 2'd3};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL restart_1047: got %h want %h", obs, exp_v); end
    step_n(1600);
    exp_v = 28'd0;
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL restart_end: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 4'b0000;
    test_reset();
    test_reset_mid_note();
    test_shoot();
    test_rest_step();
    test_preempt();
    test_simultaneous();
    test_held();
    test_same_id_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
